// File: rtl/latency_ram_arbiter.sv
// ============================================================================
// latency_ram_arbiter : round-robin share of one multi-cycle RAM slave between
//                       an instruction-fetch port (0) and a data port (1).
// Revision 1.0
// ============================================================================
`default_nettype none

module latency_ram_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic [DW-1:0] rdata0,
    output logic          done0,
    output logic          err0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic [DW-1:0] rdata1,
    output logic          done1,
    output logic          err1,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_finish,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT - 1);

    state_t        state_q;
    logic          last_grant_q;
    logic          grant_q;
    logic [7:0]    cnt_q;
    logic          mem_en_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;
    logic          done0_q;
    logic          done1_q;
    logic          err0_q;
    logic          err1_q;
    logic          busy_q;
    logic          grant_d;

    // On a tie the port that did not win last time gets the slave.
    assign grant_d = (req0 && req1) ? ~last_grant_q : req1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            cnt_q        <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req0 || req1) begin
                        grant_q     <= grant_d;
                        mem_we_q    <= grant_d ? we1    : we0;
                        mem_addr_q  <= grant_d ? addr1  : addr0;
                        mem_wdata_q <= grant_d ? wdata1 : wdata0;
                        mem_en_q    <= 1'b1;
                        cnt_q       <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // A finish on the limit cycle wins over the timeout.
                    if (mem_finish) begin
                        if (grant_q) rdata1_q <= mem_rdata;
                        else         rdata0_q <= mem_rdata;
                        done0_q  <= ~grant_q;
                        done1_q  <= grant_q;
                        mem_en_q <= 1'b0;
                        state_q  <= S_DONE;
                    end else if (cnt_q == CNT_LIMIT) begin
                        done0_q  <= ~grant_q;
                        done1_q  <= grant_q;
                        err0_q   <= ~grant_q;
                        err1_q   <= grant_q;
                        mem_en_q <= 1'b0;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_DONE: begin
                    last_grant_q <= grant_q;
                    state_q      <= S_GAP;
                end
                S_GAP: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q   <= 1'b0;
                    mem_en_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign err0      = err0_q;
    assign err1      = err1_q;
    assign busy      = busy_q;

endmodule

`default_nettype wire

// File: doc/latency_ram_arbiter.md
Name: latency_ram_arbiter

Overview:
- Shares one multi-cycle RAM slave between two requesters: port 0 is instruction fetch, port 1 is data load/store.
- The slave uses an en/we/addr/data_in/data_out/isFinish interface.
- The block does round-robin arbitration, latches the granted request, holds the slave enable until completion or timeout, and returns a one-cycle done pulse with read data to the winner.
- Sits between the CPU front end / memory stage and the shared latency RAM.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 64, cycles in BUSY before the transaction is aborted; legal range 2..255

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  asynchronous active-low reset
req0  input  1  port 0 request; hold high until done0
we0  input  1  port 0 write enable; stable while req0 is high
addr0  input  AW  port 0 address
wdata0  input  DW  port 0 write data
rdata0  output  DW  port 0 read data; valid while done0=1, then held
done0  output  1  one-cycle completion pulse, port 0
err0  output  1  high with done0 when the transaction timed out
req1, we1, addr1, wdata1, rdata1, done1, err1  same as port 0, for port 1
mem_en  output  1  slave enable
mem_we  output  1  slave write enable
mem_addr  output  AW  slave address
mem_wdata  output  DW  slave write data
mem_rdata  input  DW  slave read data
mem_finish  input  1  slave completion pulse
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; last_grant=1, so port 0 wins the first tie.
  - Timeout counter = 0.
  - All outputs 0: mem_en, mem_we, mem_addr, mem_wdata, done*, err*, rdata*, busy.
- States: IDLE, BUSY, DONE, GAP.
- IDLE:
  - Only one req high: grant it.
  - Both high: grant the port that is not last_grant.
  - On grant: register we/addr/wdata of the winner into mem_*, set mem_en=1, record grant, clear counter, go to BUSY. mem_en rises the cycle after the request is sampled.
  - No req: stay in IDLE; mem_en=0.
- BUSY:
  - mem_en and all mem_* held constant. Counter increments each cycle.
  - mem_finish=1: capture mem_rdata into rdata of the granted port (writes capture it too, value unspecified for writes), go to DONE.
  - Counter reaches TIMEOUT-1 without mem_finish: go to DONE with the timeout flag set; rdata is left unchanged.
  - mem_finish on the same cycle as the counter limit: treated as a success.
- DONE (exactly 1 cycle):
  - done of the granted port=1; err=timeout flag; mem_en=0.
  - last_grant <= granted port. Go to GAP.
- GAP (1 cycle):
  - mem_en=0; all req ignored. Lets the slave drop its finish pulse.
  - Go to IDLE.
- Requester obligations:
  - Deassert req the cycle after done is seen.
  - req still high in IDLE is a new request.
  - Dropping req before done is illegal. The arbiter completes the transaction anyway and still pulses done.
- The non-granted port's req is ignored until IDLE; its done/err stay 0.
- Minimum turnaround: request sampled N → mem_en at N+1 → finish at F → done at F+1 → IDLE at F+3.
- rst_n asserted mid-transaction: immediate return to IDLE with outputs cleared; no done pulse is issued.
- busy = (state != IDLE).

Test Plan:
- Single read: req0=1, we0=0, addr0=0x10; slave returns 0xCAFEBABE with finish 9 cycles after mem_en → mem_addr=0x10, mem_we=0 one cycle after req; done0 one cycle after finish; rdata0=0xCAFEBABE; err0=0; done1 never asserted.
- Contention, 4 back-to-back rounds: req0 and req1 both high continuously, each requester dropping and re-raising req one cycle after its done → grants out of reset are 0,1,0,1; never two consecutive grants to one port.
- Write passthrough: req1=1, we1=1, addr1=0x24, wdata1=0x12345678 → mem_en=1, mem_we=1, mem_wdata=0x12345678 held stable every BUSY cycle until finish; done1 pulses exactly once.
- Timeout: slave never finishes; TIMEOUT=64 → done0=1 and err0=1 exactly 64 cycles after mem_en rises; mem_en=0 the same cycle; rdata0 unchanged.
- Finish coincident with the timeout limit → err=0; rdata captured from mem_rdata.
- Reset mid-BUSY: rst_n pulsed low at cycle 3 of BUSY → mem_en=0 and busy=0 immediately; no done pulse. After release with req1 held high, port 1 is granted normally.
